fifo_rr_arbiter: RTL

- Round-robin arbiter that shares one fifo write port among NREQ valid/ready producers.
- Grants one producer at a time for a burst of up to BURSTLEN beats, then rotates priority.
- Sits directly in front of the fifo: valid_o/data_o/ready_i connect to the fifo's valid_i/data_i/ready_o.
- Preserves per-requester ordering; beats from different requesters are never interleaved inside a burst.

---
 rtl/fifo_arb_pkg.sv | 24 ++
 rtl/rr_picker.sv | 42 ++++
 rtl/fifo_rr_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin fifo write-port arbiter.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package fifo_arb_pkg;

  // Upper bound on requester count supported by the onehot helper.
  localparam int MAXREQ = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot of index over nreq bits; bits at or above nreq are always zero.
  function automatic logic [MAXREQ-1:0] onehot(input int index, input int nreq);
    logic [MAXREQ-1:0] r;
    r = '0;
    for (int i = 0; i < MAXREQ; i++) begin
      r[i] = (i == index) && (i < nreq);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping at NREQ-1.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
// Ports: req (request vector), ptr (priority start), found (any req set), idx (winner).
module rr_picker #(
  parameter int NREQ    = 4,
  parameter int BITSREQ = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]    req,
  input  logic [BITSREQ-1:0] ptr,
  output logic               found,
  output logic [BITSREQ-1:0] idx
);

  logic [NREQ-1:0]    rot;
  logic [BITSREQ-1:0] off;

  // Explicit modulo for sums below 2*NREQ; avoids relying on power-of-two truncation.
  function automatic int wrap(input int v);
    return (v >= NREQ) ? v - NREQ : v;
  endfunction

  always_comb begin
    // Rotate so that ptr lands at bit 0.
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = req[BITSREQ'(wrap(i + int'(ptr)))];
    end

    // Find first set bit of the rotated vector (lowest index wins).
    found = |rot;
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = BITSREQ'(i);
      end
    end

    // Un-rotate back to a requester index.
    idx = BITSREQ'(wrap(int'(off) + int'(ptr)));
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NREQ valid/ready producers.
// Latency: 1 cycle valid-to-grant, then a combinational data path; one IDLE bubble between grants.
// Backpressure: ready_i low holds the grant and beat count indefinitely; non-granted requesters see ready low.
// Ports: clk_i/rst_i (sync active-high); req_valid_i/req_data_i/req_ready_o per requester;
//        valid_o/data_o/ready_i toward the fifo; grant_o one-hot grant; busy_o high in GRANT.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int SIZEDATA  = 32,
  parameter int NREQ      = 4,
  parameter int BURSTLEN  = 4,
  parameter int BITSREQ   = $clog2(NREQ),
  parameter int BITSBURST = $clog2(BURSTLEN + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*SIZEDATA-1:0] req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic                     valid_o,
  output logic [SIZEDATA-1:0]      data_o,
  input  logic                     ready_i,
  output logic [NREQ-1:0]          grant_o,
  output logic                     busy_o
);

  localparam logic [BITSREQ-1:0]   LAST_REQ  = BITSREQ'(NREQ - 1);
  localparam logic [BITSBURST-1:0] LAST_BEAT = BITSBURST'(BURSTLEN - 1);

  state_t               state_q, state_d;
  logic [BITSREQ-1:0]   grant_q, grant_d;
  logic [BITSREQ-1:0]   ptr_q, ptr_d;
  logic [BITSBURST-1:0] count_q, count_d;

  logic               pick_found;
  logic [BITSREQ-1:0] pick_idx;
  logic               cur_valid;
  logic               xfer;

  rr_picker #(
    .NREQ    (NREQ),
    .BITSREQ (BITSREQ)
  ) u_picker (
    .req   (req_valid_i),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cur_valid = req_valid_i[grant_q];
  assign xfer      = (state_q == GRANT) && cur_valid && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          grant_d = pick_idx;
          count_d = '0;
        end
      end
      GRANT: begin
        // Release when the requester goes idle, or on the last beat of the burst.
        if (!cur_valid || (xfer && (count_q == LAST_BEAT))) begin
          state_d = IDLE;
          count_d = '0;
          ptr_d   = (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;
        end else if (xfer) begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    valid_o     = 1'b0;
    data_o      = '0;
    req_ready_o = '0;
    grant_o     = '0;
    busy_o      = 1'b0;
    if (state_q == GRANT) begin
      grant_o     = NREQ'(onehot(int'(grant_q), NREQ));
      valid_o     = cur_valid;
      data_o      = req_data_i[int'(grant_q)*SIZEDATA +: SIZEDATA];
      req_ready_o = grant_o & {NREQ{ready_i}};
      busy_o      = 1'b1;
    end
  end

endmodule
